// File: rtl/mm_result_serializer.sv
// Captures one block of parallel result rows from the matmul bridge and
// re-emits it row-major as BEAT_WIDTH beats under valid/ready flow control.
module mm_result_serializer #(
    parameter int WIDTH_OUT     = 16,
    parameter int CHUNK_SIZE    = 4,
    parameter int NUM_CORES_A   = 1,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_MODULES = 2,
    parameter int TOTAL_INPUT_W = 2,
    parameter int BEAT_WIDTH    = WIDTH_OUT * CHUNK_SIZE,
    localparam int ROW_WIDTH    = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES,
    localparam int BEATS        = ROW_WIDTH / BEAT_WIDTH,
    localparam int ROW_BITS     = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1,
    localparam int BEAT_BITS    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ROW_WIDTH-1:0]  in_data [TOTAL_INPUT_W],
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic [ROW_BITS-1:0]   out_row,
    output logic                  out_last_row_beat,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun_err,
    output logic [15:0]           block_cnt
);

    // Handshake rules: a beat transfers on any rising edge where out_valid &&
    // out_ready; a block is captured on any rising edge where in_valid &&
    // in_ready, otherwise an asserted in_valid is dropped and flagged.

    if (ROW_WIDTH % BEAT_WIDTH != 0) begin : g_bad_beat_width
        $error("mm_result_serializer: ROW_WIDTH must be a multiple of BEAT_WIDTH");
    end

    localparam logic [BEAT_BITS-1:0] BEAT_MAX = BEAT_BITS'(BEATS - 1);
    localparam logic [ROW_BITS-1:0]  ROW_MAX  = ROW_BITS'(TOTAL_INPUT_W - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ROW_WIDTH-1:0] cap [TOTAL_INPUT_W];
    logic [ROW_BITS-1:0]  row;
    logic [BEAT_BITS-1:0] beat;
    logic                 capture;
    logic                 block_done;
    logic                 row_end;
    logic                 block_end;

    assign row_end   = (beat == BEAT_MAX);
    assign block_end = row_end && (row == ROW_MAX);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        capture    = 1'b0;
        block_done = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // Final-beat handshake frees the capture register in the same
                // cycle so a waiting block starts with no bubble.
                if (out_ready && block_end) begin
                    block_done = 1'b1;
                    in_ready   = 1'b1;
                    if (in_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            beat        <= '0;
            block_cnt   <= '0;
            overrun_err <= 1'b0;
            for (int i = 0; i < TOTAL_INPUT_W; i++) begin
                cap[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (in_valid && !in_ready) begin
                overrun_err <= 1'b1;
            end
            if (capture) begin
                for (int i = 0; i < TOTAL_INPUT_W; i++) begin
                    cap[i] <= in_data[i];
                end
                row  <= '0;
                beat <= '0;
            end else if (state == STREAM && out_ready) begin
                if (row_end) begin
                    beat <= '0;
                    row  <= row + ROW_BITS'(1);
                end else begin
                    beat <= beat + BEAT_BITS'(1);
                end
            end
            if (block_done) begin
                block_cnt <= block_cnt + 16'd1;
            end
        end
    end

    assign busy      = (state == STREAM);
    assign out_valid = busy;
    assign out_row   = busy ? row : '0;

    // Qualified by busy so that the idle/reset view of the beat flags is 0,
    // which matters when BEATS==1 and beat==BEAT_MAX permanently.
    assign out_last_row_beat = busy && row_end;
    assign out_last          = busy && block_end;

    always_comb begin
        out_data = '0;
        if (busy) begin
            out_data = cap[row][beat*BEAT_WIDTH +: BEAT_WIDTH];
        end
    end

endmodule

// File: tb/tb_mm_result_serializer.sv
// Randomised and directed bench for mm_result_serializer against a queue
// model of the emitted beat stream.
module tb_mm_result_serializer;

    localparam int RW    = 128;
    localparam int BW    = 64;
    localparam int TIW   = 2;
    localparam int BEATS = RW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] in_data [TIW];
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [0:0]    out_row;
    logic          out_last_row_beat;
    logic          out_last;
    logic          busy;
    logic          overrun_err;
    logic [15:0]   block_cnt;

    mm_result_serializer dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_row           (out_row),
        .out_last_row_beat (out_last_row_beat),
        .out_last          (out_last),
        .busy              (busy),
        .overrun_err       (overrun_err),
        .block_cnt         (block_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [0:0]    row;
        logic          lrb;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    logic        m_ovr   = 1'b0;
    logic [15:0] m_cnt   = 16'd0;
    logic        m_fresh = 1'b0;
    logic        m_known = 1'b0;
    int          errors  = 0;
    int          checks  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model mid-cycle, then advance the model using the
    // inputs that the coming rising edge will see.
    always @(negedge clk) begin
        beat_t b;
        logic  rdy;
        #3;
        if (m_known) begin
            rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("in_ready", in_ready, rdy);
            chk("overrun_err", overrun_err, m_ovr);
            chk("block_cnt", block_cnt, m_cnt);
            if (exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_row", out_row, exp_q[0].row);
                chk("out_last_row_beat", out_last_row_beat, exp_q[0].lrb);
                chk("out_last", out_last, exp_q[0].last);
            end else if (m_fresh) begin
                chk("idle_out_data", out_data, 0);
                chk("idle_out_row", out_row, 0);
                chk("idle_lrb", out_last_row_beat, 0);
                chk("idle_last", out_last, 0);
            end
        end
        if (rst) begin
            exp_q.delete();
            m_ovr   = 1'b0;
            m_cnt   = 16'd0;
            m_fresh = 1'b1;
            m_known = 1'b1;
        end else if (m_known) begin
            rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            if (out_ready && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                if (b.last) m_cnt = m_cnt + 16'd1;
            end
            if (in_valid) begin
                if (rdy) begin
                    m_fresh = 1'b0;
                    for (int r = 0; r < TIW; r++) begin
                        for (int k = 0; k < BEATS; k++) begin
                            b.data = in_data[r][k*BW +: BW];
                            b.row  = 1'(r);
                            b.lrb  = (k == BEATS - 1);
                            b.last = (k == BEATS - 1) && (r == TIW - 1);
                            exp_q.push_back(b);
                        end
                    end
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_random();
        for (int r = 0; r < TIW; r++) begin
            in_data[r] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Waits for the DUT to go idle; a blown budget counts as a failure.
    task automatic drain(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            #2;
            if (!out_valid) done = 1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: out_valid still 1 after %0d cycles", budget);
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < TIW; r++) in_data[r] = '0;
        repeat (3) tick();
        rst = 1'b0;
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_block_cnt", block_cnt, 0);

        // Single block with known data.
        tick();
        in_data[0] = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        in_data[1] = 128'h0011_0012_0013_0014_0015_0016_0017_0018;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        chk("t1_model_beat0", exp_q[0].data, 64'h0005_0006_0007_0008);
        chk("t1_beat0", out_data, 64'h0005_0006_0007_0008);
        tick(); #2;
        chk("t1_beat1", out_data, 64'h0001_0002_0003_0004);
        chk("t1_beat1_lrb", out_last_row_beat, 1);
        tick(); #2;
        chk("t1_beat2", out_data, 64'h0015_0016_0017_0018);
        chk("t1_beat2_last", out_last, 0);
        tick(); #2;
        chk("t1_beat3", out_data, 64'h0011_0012_0013_0014);
        chk("t1_beat3_last", out_last, 1);
        tick(); #2;
        chk("t1_cnt", block_cnt, 1);
        chk("t1_idle", out_valid, 0);

        // Backpressure with out_ready pattern 1,0,0,1.
        tick();
        load_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && (out_valid || i == 0); i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            #2;
            if (out_valid && out_ready) n++;
            tick();
        end
        out_ready = 1'b1;
        chk("bp_beats", n, 4);
        #2;
        chk("bp_cnt", block_cnt, 2);

        // Back-to-back: second block presented during the final-beat handshake.
        tick();
        load_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        #2;
        while (!out_last && n < 20) begin
            tick(); #2;
            n++;
        end
        chk("b2b_reached_last", out_last, 1);
        in_data[0] = 128'hAAAA_BBBB_CCCC_DDDD_1234_5678_9ABC_DEF0;
        in_data[1] = 128'h8000_7FFF_FFFF_0001_0F0F_F0F0_5555_AAAA;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        chk("b2b_beat0", out_data, 64'h1234_5678_9ABC_DEF0);
        chk("b2b_busy", busy, 1);
        drain(20);
        chk("b2b_cnt", block_cnt, 4);
        chk("b2b_no_overrun", overrun_err, 0);

        // Overrun during beat 2 of a block.
        tick();
        load_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_data[0] = '1;
        in_data[1] = '1;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        chk("ovr_set", overrun_err, 1);
        drain(20);
        chk("ovr_sticky", overrun_err, 1);
        chk("ovr_cnt", block_cnt, 5);

        // Reset after beat 1 of a block.
        tick();
        load_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_cnt", block_cnt, 0);
        chk("rst_ovr", overrun_err, 0);
        tick();
        load_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(20);
        chk("rst_fresh_cnt", block_cnt, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            tick();
            load_random();
            in_valid  = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(20);

        // Counter wrap via preload.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        #1;
        force dut.block_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.block_cnt;
        tick();
        load_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(20);
        chk("wrap_cnt", block_cnt, 0);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
